// File: rtl/systolic_feeder_2x2_if.sv
// ---------------------------------------------------------------------------
// systolic_feeder_2x2_if
// Bundles the upstream matrix-pair handshake and the skewed array-side
// lanes of the 2x2 systolic feeder.
//   s_valid / s_ready        : upstream valid/ready handshake
//   s_a00..s_a11             : A (data) matrix elements offered upstream
//   s_b00..s_b11             : B (weight) matrix elements offered upstream
//   in_valid                 : array data lanes carry live A operands
//   a00..a11 / b00..b11      : skewed operand lanes toward the array
//   busy                     : feeder holds or is still replaying a set
// Modports:
//   slave  : the feeder itself
//   master : the upstream source and array-side observer
// ---------------------------------------------------------------------------
interface systolic_feeder_2x2_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_a00;
    logic [DATA_WIDTH-1:0] s_a01;
    logic [DATA_WIDTH-1:0] s_a10;
    logic [DATA_WIDTH-1:0] s_a11;
    logic [DATA_WIDTH-1:0] s_b00;
    logic [DATA_WIDTH-1:0] s_b01;
    logic [DATA_WIDTH-1:0] s_b10;
    logic [DATA_WIDTH-1:0] s_b11;

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] a00;
    logic [DATA_WIDTH-1:0] a01;
    logic [DATA_WIDTH-1:0] a10;
    logic [DATA_WIDTH-1:0] a11;
    logic [DATA_WIDTH-1:0] b00;
    logic [DATA_WIDTH-1:0] b01;
    logic [DATA_WIDTH-1:0] b10;
    logic [DATA_WIDTH-1:0] b11;
    logic                  busy;

    modport slave (
        input  s_valid, s_a00, s_a01, s_a10, s_a11,
               s_b00, s_b01, s_b10, s_b11,
        output s_ready, in_valid, a00, a01, a10, a11,
               b00, b01, b10, b11, busy
    );

    modport master (
        output s_valid, s_a00, s_a01, s_a10, s_a11,
               s_b00, s_b01, s_b10, s_b11,
        input  s_ready, in_valid, a00, a01, a10, a11,
               b00, b01, b10, b11, busy
    );
endinterface

// File: rtl/systolic_feeder_2x2.sv
// ---------------------------------------------------------------------------
// systolic_feeder_2x2
// Upstream operand scheduler for a 2x2 weight-stationary systolic array.
// Whole A/B matrix pairs are accepted over valid/ready, buffered in a small
// FIFO, and replayed onto the array lanes in diagonal-skewed order:
//   k=0: b01   k=1: b00,b10   k=2: b11,a00   k=3: a01,a10   k=4: a11
// where k is the cycle count after the pop edge. A pop is followed by one
// forced gap cycle, so consecutive sets overlap at one set per 2 cycles.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : systolic_feeder_2x2_if.slave (handshake, operand lanes, busy)
// All bus outputs are registered.
// ---------------------------------------------------------------------------
module systolic_feeder_2x2 #(
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_feeder_2x2_if.slave bus
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    // Replay stages held after the pop edge (k=1..4 sources); k=0 comes
    // straight from the FIFO head.
    localparam int PIPE_N = 4;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(32'd0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(32'd1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a00;
        logic [DATA_WIDTH-1:0] a01;
        logic [DATA_WIDTH-1:0] a10;
        logic [DATA_WIDTH-1:0] a11;
        logic [DATA_WIDTH-1:0] b00;
        logic [DATA_WIDTH-1:0] b01;
        logic [DATA_WIDTH-1:0] b10;
        logic [DATA_WIDTH-1:0] b11;
    } set_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // FIFO storage and bookkeeping
    set_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Replay pipeline: index i holds the set that is at k=i+1 next cycle
    set_t              stg_q   [PIPE_N];
    set_t              stg_d   [PIPE_N];
    logic [PIPE_N-1:0] stg_v_q, stg_v_d;

    // FSM
    state_e state_q, state_d;

    // Registered outputs
    set_t out_q,      out_d;
    logic in_valid_q, in_valid_d;
    logic busy_q,     busy_d;
    logic s_ready_q,  s_ready_d;

    // Handshake helpers
    logic push_s;
    logic pop_s;
    set_t in_set_s;
    set_t head_s;

    // Gather the offered upstream pair and the current FIFO head
    always_comb begin
        in_set_s.a00 = bus.s_a00;
        in_set_s.a01 = bus.s_a01;
        in_set_s.a10 = bus.s_a10;
        in_set_s.a11 = bus.s_a11;
        in_set_s.b00 = bus.s_b00;
        in_set_s.b01 = bus.s_b01;
        in_set_s.b10 = bus.s_b10;
        in_set_s.b11 = bus.s_b11;
        head_s       = mem_q[rd_ptr_q];
    end

    // Push uses the registered ready so an entry written this edge is only
    // visible to the pop logic from the next edge on (no bypass).
    always_comb begin
        push_s = bus.s_valid && s_ready_q;
        pop_s  = (count_q != CNT_ZERO) && (state_q != ST_GAP);
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= in_set_s;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Replay pipeline next-state: the popped set enters index 0, the rest shift
    always_comb begin
        stg_v_d  = {stg_v_q[PIPE_N-2:0], pop_s};
        stg_d[0] = pop_s ? head_s : '0;
        for (int i = 1; i < PIPE_N; i++) begin
            stg_d[i] = stg_q[i-1];
        end
    end

    // Replay pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_v_q <= {PIPE_N{1'b0}};
            for (int i = 0; i < PIPE_N; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_v_q <= stg_v_d;
            for (int i = 0; i < PIPE_N; i++) begin
                stg_q[i] <= stg_d[i];
            end
        end
    end

    // FSM next-state. DRAIN retires only once every replay stage is empty,
    // so busy stays high through the k=4 cycle of the last set.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = pop_s ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop_s) begin
                    state_d = ST_GAP;
                end else if ((stg_v_q == {PIPE_N{1'b0}}) && (count_q == CNT_ZERO)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Lane muxes: each lane is owned by exactly one replay stage, so a plain
    // select-or-zero per lane is enough; 2-cycle spacing keeps owners apart.
    always_comb begin
        out_d     = '0;
        out_d.b01 = pop_s      ? head_s.b01   : {DATA_WIDTH{1'b0}};
        out_d.b00 = stg_v_q[0] ? stg_q[0].b00 : {DATA_WIDTH{1'b0}};
        out_d.b10 = stg_v_q[0] ? stg_q[0].b10 : {DATA_WIDTH{1'b0}};
        out_d.b11 = stg_v_q[1] ? stg_q[1].b11 : {DATA_WIDTH{1'b0}};
        out_d.a00 = stg_v_q[1] ? stg_q[1].a00 : {DATA_WIDTH{1'b0}};
        out_d.a01 = stg_v_q[2] ? stg_q[2].a01 : {DATA_WIDTH{1'b0}};
        out_d.a10 = stg_v_q[2] ? stg_q[2].a10 : {DATA_WIDTH{1'b0}};
        out_d.a11 = stg_v_q[3] ? stg_q[3].a11 : {DATA_WIDTH{1'b0}};
        // A operands are live at k=2..4
        in_valid_d = stg_v_q[1] | stg_v_q[2] | stg_v_q[3];
        busy_d     = (state_d != ST_IDLE) || (count_d != CNT_ZERO);
        s_ready_d  = (count_d != CNT_FULL);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            in_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            s_ready_q  <= 1'b1;
        end else begin
            out_q      <= out_d;
            in_valid_q <= in_valid_d;
            busy_q     <= busy_d;
            s_ready_q  <= s_ready_d;
        end
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.in_valid = in_valid_q;
    assign bus.busy     = busy_q;
    assign bus.a00      = out_q.a00;
    assign bus.a01      = out_q.a01;
    assign bus.a10      = out_q.a10;
    assign bus.a11      = out_q.a11;
    assign bus.b00      = out_q.b00;
    assign bus.b01      = out_q.b01;
    assign bus.b10      = out_q.b10;
    assign bus.b11      = out_q.b11;

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder_2x2
// Scoreboard bench for systolic_feeder_2x2: accepted sets are queued when
// driven, and a cycle timeline of expected lane values is built from the
// skew table whenever a pop is due. Every negedge the DUT lanes, in_valid,
// busy and s_ready are compared against that timeline.
// ---------------------------------------------------------------------------
module tb_systolic_feeder_2x2;

    localparam int DW    = 4;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [DW-1:0] a00;
        logic [DW-1:0] a01;
        logic [DW-1:0] a10;
        logic [DW-1:0] a11;
        logic [DW-1:0] b00;
        logic [DW-1:0] b01;
        logic [DW-1:0] b10;
        logic [DW-1:0] b11;
    } set_t;

    typedef struct packed {
        logic          live;
        logic          iv;
        logic [DW-1:0] a00;
        logic [DW-1:0] a01;
        logic [DW-1:0] a10;
        logic [DW-1:0] a11;
        logic [DW-1:0] b00;
        logic [DW-1:0] b01;
        logic [DW-1:0] b10;
        logic [DW-1:0] b11;
    } frame_t;

    logic clk = 1'b0;
    logic rst;

    systolic_feeder_2x2_if #(.DATA_WIDTH(DW)) bus_if ();

    systolic_feeder_2x2 #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Scoreboard / timeline model state
    set_t   sb_q [$];
    frame_t fr [5];
    int     m_count;
    bit     m_gap;
    bit     m_pushed;

    int checks;
    int errors;

    // Observation statistics
    int iv_run, iv_max, iv_count, rdy_low_cnt, lane_hits;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic set_t mk_set(input int a00, input int a01, input int a10, input int a11,
                                    input int b00, input int b01, input int b10, input int b11);
        set_t s;
        s.a00 = DW'(a00); s.a01 = DW'(a01); s.a10 = DW'(a10); s.a11 = DW'(a11);
        s.b00 = DW'(b00); s.b01 = DW'(b01); s.b10 = DW'(b10); s.b11 = DW'(b11);
        return s;
    endfunction

    task automatic drive(input set_t s, input logic v);
        bus_if.s_valid = v;
        bus_if.s_a00 = s.a00; bus_if.s_a01 = s.a01; bus_if.s_a10 = s.a10; bus_if.s_a11 = s.a11;
        bus_if.s_b00 = s.b00; bus_if.s_b01 = s.b01; bus_if.s_b10 = s.b10; bus_if.s_b11 = s.b11;
    endtask

    // One clock: update the model on the edge, compare on the following negedge
    task automatic step();
        set_t   cur;
        set_t   popped;
        bit     pop_m;
        bit     push_m;
        bit     busy_m;
        int     hits;
        @(posedge clk);
        if (rst) begin
            sb_q.delete();
            for (int j = 0; j < 5; j++) fr[j] = '0;
            m_count  = 0;
            m_gap    = 1'b0;
            m_pushed = 1'b0;
        end else begin
            pop_m  = (m_count != 0) && !m_gap;
            push_m = bus_if.s_valid && (m_count != DEPTH);
            cur = mk_set(bus_if.s_a00, bus_if.s_a01, bus_if.s_a10, bus_if.s_a11,
                         bus_if.s_b00, bus_if.s_b01, bus_if.s_b10, bus_if.s_b11);
            for (int j = 0; j < 4; j++) fr[j] = fr[j+1];
            fr[4] = '0;
            if (pop_m) begin
                popped = sb_q.pop_front();
                fr[0].live = 1'b1; fr[0].b01 = popped.b01;
                fr[1].live = 1'b1; fr[1].b00 = popped.b00; fr[1].b10 = popped.b10;
                fr[2].live = 1'b1; fr[2].iv = 1'b1; fr[2].b11 = popped.b11; fr[2].a00 = popped.a00;
                fr[3].live = 1'b1; fr[3].iv = 1'b1; fr[3].a01 = popped.a01; fr[3].a10 = popped.a10;
                fr[4].live = 1'b1; fr[4].iv = 1'b1; fr[4].a11 = popped.a11;
            end
            if (push_m) sb_q.push_back(cur);
            m_count  = m_count + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
            m_gap    = pop_m;
            m_pushed = push_m;
        end
        @(negedge clk);
        busy_m = (m_count != 0);
        for (int j = 0; j < 5; j++) if (fr[j].live) busy_m = 1'b1;
        check_value("ctl{s_ready,busy,in_valid}",
                    {bus_if.s_ready, bus_if.busy, bus_if.in_valid},
                    {(m_count != DEPTH), busy_m, fr[0].iv});
        check_value("a_lanes", {bus_if.a00, bus_if.a01, bus_if.a10, bus_if.a11},
                    {fr[0].a00, fr[0].a01, fr[0].a10, fr[0].a11});
        check_value("b_lanes", {bus_if.b00, bus_if.b01, bus_if.b10, bus_if.b11},
                    {fr[0].b00, fr[0].b01, fr[0].b10, fr[0].b11});
        if (bus_if.in_valid) begin
            iv_run++;
            iv_count++;
            if (iv_run > iv_max) iv_max = iv_run;
        end else begin
            iv_run = 0;
        end
        if (!bus_if.s_ready) rdy_low_cnt++;
        hits = 0;
        if (bus_if.a00 != '0) hits++;
        if (bus_if.a01 != '0) hits++;
        if (bus_if.a10 != '0) hits++;
        if (bus_if.a11 != '0) hits++;
        if (bus_if.b00 != '0) hits++;
        if (bus_if.b01 != '0) hits++;
        if (bus_if.b10 != '0) hits++;
        if (bus_if.b11 != '0) hits++;
        lane_hits += hits;
    endtask

    // Offer each set with s_valid held until the model says it was accepted
    task automatic push_list(input set_t list [$]);
        int i;
        int budget;
        i = 0;
        budget = 0;
        while ((i < list.size()) && (budget < 200)) begin
            drive(list[i], 1'b1);
            step();
            if (m_pushed) i++;
            budget++;
        end
        bus_if.s_valid = 1'b0;
        check_value("push_accept_count", i, list.size());
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    set_t  list [$];
    set_t  s1, s2, s3;
    logic [63:0] exp2 [6];

    initial begin
        checks = 0; errors = 0;
        iv_run = 0; iv_max = 0; iv_count = 0; rdy_low_cnt = 0; lane_hits = 0;
        m_count = 0; m_gap = 1'b0; m_pushed = 1'b0;
        for (int j = 0; j < 5; j++) fr[j] = '0;
        rst = 1'b1;
        drive('0, 1'b0);

        // 1. Reset held 3 cycles, then idle
        idle_steps(3);
        rst = 1'b0;
        idle_steps(2);
        check_value("reset_ctl", {bus_if.s_ready, bus_if.busy, bus_if.in_valid}, 3'b100);
        check_value("reset_lanes", {bus_if.a00, bus_if.a01, bus_if.a10, bus_if.a11,
                                    bus_if.b00, bus_if.b01, bus_if.b10, bus_if.b11}, 32'd0);

        // 2. Single set, explicit skew table {busy,iv,b01,b00,b10,b11,a00,a01,a10,a11}
        s1 = mk_set(4, 3, 12, 4, 4, 2, 6, 8);
        exp2[0] = {1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,  4'd0};
        exp2[1] = {1'b1, 1'b0, 4'd0, 4'd4, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0,  4'd0};
        exp2[2] = {1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd8, 4'd4, 4'd0, 4'd0,  4'd0};
        exp2[3] = {1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd12, 4'd0};
        exp2[4] = {1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,  4'd4};
        exp2[5] = {1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,  4'd0};
        list = '{s1};
        push_list(list);
        for (int k = 0; k < 6; k++) begin
            step();
            check_value($sformatf("single_set_k%0d", k),
                        {bus_if.busy, bus_if.in_valid, bus_if.b01, bus_if.b00, bus_if.b10,
                         bus_if.b11, bus_if.a00, bus_if.a01, bus_if.a10, bus_if.a11}, exp2[k]);
        end
        idle_steps(2);

        // 3. Three sets back-to-back
        s2 = mk_set(12, 14, 10, 1, 7, 4, 8, 1);
        s3 = mk_set(2, 3, 4, 9, 3, 0, 5, 7);
        iv_run = 0; iv_max = 0;
        list = '{s1, s2, s3};
        push_list(list);
        step();
        check_value("overlap_k2{b11,b01,a00}", {bus_if.b11, bus_if.b01, bus_if.a00}, {4'd8, 4'd4, 4'd4});
        idle_steps(2);
        check_value("overlap_k4{a11,b11,a00}", {bus_if.a11, bus_if.b11, bus_if.a00}, {4'd4, 4'd1, 4'd12});
        idle_steps(10);
        check_value("overlap_in_valid_run", iv_max, 7);

        // 4. Five distinct sets, s_valid held: backpressure
        rdy_low_cnt = 0;
        list.delete();
        for (int i = 0; i < 5; i++) begin
            list.push_back(mk_set(i*3+1, i*3+2, i*3+3, i*3+4, i*3+5, i*3+6, i*3+7, i*3+8));
        end
        push_list(list);
        idle_steps(14);
        check_value("backpressure_ready_dropped", (rdy_low_cnt != 0), 1'b1);
        check_value("backpressure_idle_after", {bus_if.busy, bus_if.in_valid}, 2'b00);

        // 5. Reset pulse at k=3 of set 1 with set 2 behind it
        list = '{s1, s2};
        push_list(list);
        idle_steps(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_value("midreset_ctl", {bus_if.s_ready, bus_if.busy, bus_if.in_valid}, 3'b100);
        iv_count = 0;
        lane_hits = 0;
        idle_steps(10);
        check_value("midreset_no_emit", {iv_count[15:0], lane_hits[15:0]}, 32'd0);

        // 6. All-15 set: each lane nonzero exactly once
        lane_hits = 0;
        list = '{mk_set(15, 15, 15, 15, 15, 15, 15, 15)};
        push_list(list);
        idle_steps(8);
        check_value("all15_lane_hits", lane_hits, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
